alu_fault_campaign_ctrl: RTL and testbench

Sequencer that runs a stuck-at fault campaign on operand a of the 16-bit ALU. It drives a shared stimulus to a golden ALU and a fault-injection ALU, and compares their result and cout outputs. It walks every a-bit through SA0 and SA1 with fault dropping, and reports per-fault detection bitmaps plus a coverage count. It sits beside the two ALU instances and replaces bench-driven ATPG loops with synthesizable control.

---
 rtl/atpg_pkg.sv | 26 ++
 rtl/atpg_lfsr32.sv | 30 +++
 rtl/alu_fault_campaign_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_alu_fault_campaign_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/atpg_pkg.sv
// Shared types and constants for the ALU operand-a stuck-at fault campaign.
package atpg_pkg;

  // Campaign sequencer states; each pattern attempt walks the four middle states.
  typedef enum logic [2:0] {
    IDLE,
    APPLY_CLEAN,
    CHECK_CLEAN,
    APPLY_FAULT,
    CHECK_FAULT,
    DONE
  } state_t;

  // Right-shift Galois feedback mask for x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Stuck-at polarity encoding.
  localparam logic SA0 = 1'b0;
  localparam logic SA1 = 1'b1;

  // One Galois step: shift right, fold the polynomial in when the bit leaving is 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] q);
    return (q >> 1) ^ ({32{q[0]}} & LFSR_POLY);
  endfunction

endpackage

// File: rtl/atpg_lfsr32.sv
// 32-bit Galois LFSR pattern source; load takes priority over step.
module atpg_lfsr32
  import atpg_pkg::*;
#(
  parameter logic [31:0] RESET_VALUE = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  logic [31:0] q_reg;

  // Reload on request, otherwise advance one step when asked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= RESET_VALUE;
    end else if (load) begin
      q_reg <= seed;
    end else if (step) begin
      q_reg <= lfsr_next(q_reg);
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/alu_fault_campaign_ctrl.sv
// Stuck-at fault campaign sequencer for operand a of a 16-bit ALU pair.
// Drives a golden and a fault-injection ALU with shared stimulus, compares
// result/cout, and walks every a-bit through SA0 then SA1 with fault dropping.
module alu_fault_campaign_ctrl
  import atpg_pkg::*;
#(
  parameter int          WIDTH        = 16,
  parameter int          NUM_PATTERNS = 4,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_2468
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] cfg_a,
  input  logic [WIDTH-1:0] cfg_b,
  input  logic [1:0]       cfg_alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  output logic [WIDTH-1:0] fault_mask_a,
  output logic [WIDTH-1:0] fault_value_a,
  input  logic [WIDTH-1:0] result_golden,
  input  logic [WIDTH-1:0] result_faulty,
  input  logic             cout_golden,
  input  logic             cout_faulty,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] det_sa0,
  output logic [WIDTH-1:0] det_sa1,
  output logic [5:0]       det_count
);

  localparam logic [3:0] LAST_PAT  = 4'(NUM_PATTERNS - 1);
  localparam logic [3:0] LAST_SITE = 4'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [3:0]       site_reg, site_next;
  logic             pol_reg, pol_next;
  logic [3:0]       pat_reg, pat_next;
  logic [WIDTH-1:0] cfg_a_reg, cfg_a_next;
  logic [WIDTH-1:0] cfg_b_reg, cfg_b_next;
  logic [WIDTH-1:0] alu_a_reg, alu_a_next;
  logic [WIDTH-1:0] alu_b_reg, alu_b_next;
  logic [1:0]       alu_sel_reg, alu_sel_next;
  logic [WIDTH-1:0] mask_reg, mask_next;
  logic [WIDTH-1:0] value_reg, value_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic [WIDTH-1:0] det_sa0_reg, det_sa0_next;
  logic [WIDTH-1:0] det_sa1_reg, det_sa1_next;
  logic [5:0]       det_count_reg, det_count_next;

  logic             lfsr_load;
  logic             lfsr_step;
  logic [31:0]      lfsr_q;
  logic             mismatch;
  logic [WIDTH-1:0] site_onehot;

  // Pattern generator shared by every fault; reloaded so each fault sees the same sequence.
  atpg_lfsr32 #(
    .RESET_VALUE (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (LFSR_SEED),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  // Decode the current fault site into a one-hot injection mask.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_site_decode
    assign site_onehot[gi] = (site_reg == 4'(gi));
  end

  assign mismatch = (result_golden != result_faulty) | (cout_golden != cout_faulty);

  // State and output registers; everything the block drives comes straight from here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      site_reg      <= '0;
      pol_reg       <= SA0;
      pat_reg       <= '0;
      cfg_a_reg     <= '0;
      cfg_b_reg     <= '0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_sel_reg   <= '0;
      mask_reg      <= '0;
      value_reg     <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      det_sa0_reg   <= '0;
      det_sa1_reg   <= '0;
      det_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      site_reg      <= site_next;
      pol_reg       <= pol_next;
      pat_reg       <= pat_next;
      cfg_a_reg     <= cfg_a_next;
      cfg_b_reg     <= cfg_b_next;
      alu_a_reg     <= alu_a_next;
      alu_b_reg     <= alu_b_next;
      alu_sel_reg   <= alu_sel_next;
      mask_reg      <= mask_next;
      value_reg     <= value_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      det_sa0_reg   <= det_sa0_next;
      det_sa1_reg   <= det_sa1_next;
      det_count_reg <= det_count_next;
    end
  end

  // Next-state and next-output logic. Values set while in an APPLY state are
  // registered at its end, so the following CHECK state sees the ALUs settled.
  always_comb begin
    state_next     = state_reg;
    site_next      = site_reg;
    pol_next       = pol_reg;
    pat_next       = pat_reg;
    cfg_a_next     = cfg_a_reg;
    cfg_b_next     = cfg_b_reg;
    alu_a_next     = alu_a_reg;
    alu_b_next     = alu_b_reg;
    alu_sel_next   = alu_sel_reg;
    mask_next      = mask_reg;
    value_next     = value_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    err_next       = err_reg;
    det_sa0_next   = det_sa0_reg;
    det_sa1_next   = det_sa1_reg;
    det_count_next = det_count_reg;
    lfsr_load      = 1'b0;
    lfsr_step      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          cfg_a_next     = cfg_a;
          cfg_b_next     = cfg_b;
          alu_sel_next   = cfg_alu_sel;
          det_sa0_next   = '0;
          det_sa1_next   = '0;
          det_count_next = '0;
          err_next       = 1'b0;
          site_next      = '0;
          pol_next       = SA0;
          pat_next       = '0;
          busy_next      = 1'b1;
          lfsr_load      = 1'b1;
          state_next     = APPLY_CLEAN;
        end
      end

      APPLY_CLEAN: begin
        mask_next  = '0;
        value_next = '0;
        if (pat_reg == 4'd0) begin
          alu_a_next = cfg_a_reg;
          alu_b_next = cfg_b_reg;
        end else begin
          alu_a_next = lfsr_q[31:16];
          alu_b_next = lfsr_q[15:0];
        end
        state_next = CHECK_CLEAN;
      end

      CHECK_CLEAN: begin
        if (mismatch) begin
          // Disagreement with nothing injected means the ALU pair is broken; abort.
          err_next   = 1'b1;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = DONE;
        end else begin
          state_next = APPLY_FAULT;
        end
      end

      APPLY_FAULT: begin
        mask_next  = site_onehot;
        value_next = pol_reg ? site_onehot : '0;
        state_next = CHECK_FAULT;
      end

      CHECK_FAULT: begin
        if (!mismatch && (pat_reg != LAST_PAT)) begin
          pat_next   = pat_reg + 4'd1;
          lfsr_step  = 1'b1;
          state_next = APPLY_CLEAN;
        end else begin
          if (mismatch) begin
            if (pol_reg == SA0) begin
              det_sa0_next[site_reg] = 1'b1;
            end else begin
              det_sa1_next[site_reg] = 1'b1;
            end
            det_count_next = det_count_reg + 6'd1;
          end
          // Move on to the next fault without spending a cycle on it.
          pat_next  = '0;
          lfsr_load = 1'b1;
          if (pol_reg == SA0) begin
            pol_next   = SA1;
            state_next = APPLY_CLEAN;
          end else if (site_reg == LAST_SITE) begin
            mask_next  = '0;
            value_next = '0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = DONE;
          end else begin
            pol_next   = SA0;
            site_next  = site_reg + 4'd1;
            state_next = APPLY_CLEAN;
          end
        end
      end

      DONE: begin
        // Start is deliberately not sampled here; results hold until the next start.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign alu_a         = alu_a_reg;
  assign alu_b         = alu_b_reg;
  assign alu_sel       = alu_sel_reg;
  assign fault_mask_a  = mask_reg;
  assign fault_value_a = value_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign err           = err_reg;
  assign det_sa0       = det_sa0_reg;
  assign det_sa1       = det_sa1_reg;
  assign det_count     = det_count_reg;

endmodule

// File: tb/tb_alu_fault_campaign_ctrl.sv
// Directed bench: two campaign controllers (1 and 4 patterns) each wired to a
// behavioural golden/faulty ALU pair.
module tb_alu_fault_campaign_ctrl;

  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] cfg_a, cfg_b;
  logic [1:0]  cfg_sel;
  logic        start1, start4, corrupt;

  logic [15:0] a1, b1, m1, v1, rg1, rf1, ds0_1, ds1_1;
  logic [1:0]  s1;
  logic        cg1, cf1, busy1, done1, err1;
  logic [5:0]  cnt1;
  logic [16:0] f1;

  logic [15:0] a4, b4, m4, v4, rg4, rf4, ds0_4, ds1_4;
  logic [1:0]  s4;
  logic        cg4, cf4, busy4, done4, err4;
  logic [5:0]  cnt4;
  logic [16:0] f4;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural ALU: 00 AND, 01 OR, 10 ADD, 11 XOR; returns {cout, result}.
  function automatic logic [16:0] alu(input logic [15:0] a, input logic [15:0] b,
                                      input logic [1:0] sel);
    case (sel)
      2'b00:   return {1'b0, a & b};
      2'b01:   return {1'b0, a | b};
      2'b10:   return {1'b0, a} + {1'b0, b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] q);
    return (q >> 1) ^ ({32{q[0]}} & 32'h8020_0003);
  endfunction

  assign {cg1, rg1} = alu(a1, b1, s1);
  assign f1         = alu((a1 & ~m1) | (v1 & m1), b1, s1);
  assign cf1        = f1[16];
  assign rf1        = f1[15:0] ^ {15'd0, corrupt};

  assign {cg4, rg4} = alu(a4, b4, s4);
  assign f4         = alu((a4 & ~m4) | (v4 & m4), b4, s4);
  assign cf4        = f4[16];
  assign rf4        = f4[15:0];

  alu_fault_campaign_ctrl #(.WIDTH(16), .NUM_PATTERNS(1), .LFSR_SEED(SEED)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cfg_a(cfg_a), .cfg_b(cfg_b),
    .cfg_alu_sel(cfg_sel), .alu_a(a1), .alu_b(b1), .alu_sel(s1),
    .fault_mask_a(m1), .fault_value_a(v1), .result_golden(rg1), .result_faulty(rf1),
    .cout_golden(cg1), .cout_faulty(cf1), .busy(busy1), .done(done1), .err(err1),
    .det_sa0(ds0_1), .det_sa1(ds1_1), .det_count(cnt1)
  );

  alu_fault_campaign_ctrl #(.WIDTH(16), .NUM_PATTERNS(4), .LFSR_SEED(SEED)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .cfg_a(cfg_a), .cfg_b(cfg_b),
    .cfg_alu_sel(cfg_sel), .alu_a(a4), .alu_b(b4), .alu_sel(s4),
    .fault_mask_a(m4), .fault_value_a(v4), .result_golden(rg4), .result_faulty(rf4),
    .cout_golden(cg4), .cout_faulty(cf4), .busy(busy4), .done(done4), .err(err4),
    .det_sa0(ds0_4), .det_sa1(ds1_4), .det_count(cnt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Start one controller and count cycles from the start edge until done is seen.
  task automatic run_dut(input int which, output int lat);
    if (which == 1) start1 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
    lat = 0;
    while (((which == 1) ? done1 : done4) !== 1'b1 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int          lat, exp_lat4, first;
  logic [15:0] pa [4];
  logic [15:0] exp_sa0, exp_sa1;
  logic [31:0] lf;

  initial begin
    cfg_a = '0; cfg_b = '0; cfg_sel = '0;
    start1 = 1'b0; start4 = 1'b0; corrupt = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_err", 32'(err1), 32'd0);
    check("rst_alu_ab", {a1, b1}, 32'd0);
    check("rst_sel_mask_val", {14'd0, s1, m1 | v1}, 32'd0);
    check("rst_det", {ds0_1 | ds1_1, 10'd0, cnt1}, 32'd0);
    check("rst_dut4_det", {ds0_4 | ds1_4, 10'd0, cnt4}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Scenario 1: alternating operands, ADD, one pattern per fault
    cfg_a = 16'hAAAA; cfg_b = 16'h5555; cfg_sel = 2'b10;
    run_dut(1, lat);
    check("s1_latency", 32'(lat), 32'd128);
    check("s1_busy_at_done", 32'(busy1), 32'd0);
    check("s1_sa0", 32'(ds0_1), 32'hAAAA);
    check("s1_sa1", 32'(ds1_1), 32'h5555);
    check("s1_count", 32'(cnt1), 32'd16);
    check("s1_err", 32'(err1), 32'd0);
    check("s1_mask_at_done", 32'(m1 | v1), 32'd0);
    @(negedge clk);
    check("s1_done_pulse", 32'(done1), 32'd0);

    // Scenario 2: same cfg, four patterns; derive expected drops from the LFSR sequence.
    // With ADD and a 17-bit sum, any change of a changes the output, so a fault
    // on bit i is detected by the first pattern whose a[i] differs from the stuck value.
    pa[0] = 16'hAAAA;
    lf = SEED;
    for (int j = 1; j < 4; j++) begin
      lf = lfsr_step(lf);
      pa[j] = lf[31:16];
    end
    exp_sa0 = '0; exp_sa1 = '0; exp_lat4 = 0;
    for (int i = 0; i < 16; i++) begin
      for (int p = 0; p < 2; p++) begin
        first = -1;
        for (int j = 0; j < 4; j++) begin
          if (first < 0 && pa[j][i] != p[0]) first = j;
        end
        if (first >= 0) begin
          if (p == 0) exp_sa0[i] = 1'b1; else exp_sa1[i] = 1'b1;
          exp_lat4 += 4 * (first + 1);
        end else begin
          exp_lat4 += 16;
        end
      end
    end
    run_dut(4, lat);
    check("s2_latency", 32'(lat), 32'(exp_lat4));
    check("s2_sa0", 32'(ds0_4), 32'(exp_sa0));
    check("s2_sa1", 32'(ds1_4), 32'(exp_sa1));
    check("s2_count", 32'(cnt4), 32'($countones(exp_sa0) + $countones(exp_sa1)));
    check("s2_count_ge16", 32'(cnt4 >= 6'd16), 32'd1);
    check("s2_err", 32'(err4), 32'd0);
    @(negedge clk);

    // Scenario 3: faulty ALU broken with nothing injected -> abort on first clean check
    corrupt = 1'b1;
    run_dut(1, lat);
    check("s3_latency", 32'(lat), 32'd2);
    check("s3_err", 32'(err1), 32'd1);
    check("s3_count", 32'(cnt1), 32'd0);
    check("s3_det", 32'(ds0_1 | ds1_1), 32'd0);
    corrupt = 1'b0;
    @(negedge clk);
    check("s3_err_sticky", 32'(err1), 32'd1);

    // Scenario 4: asynchronous reset while site 7 is under test
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (59) @(negedge clk);
    check("s4_pre_rst_partial", 32'(ds0_1 != 16'd0), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("s4_rst_busy", 32'(busy1), 32'd0);
    check("s4_rst_det", {ds0_1 | ds1_1, 10'd0, cnt1}, 32'd0);
    check("s4_rst_drive", {a1, m1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_dut(1, lat);
    check("s4_latency", 32'(lat), 32'd128);
    check("s4_sa0", 32'(ds0_1), 32'hAAAA);
    check("s4_sa1", 32'(ds1_1), 32'h5555);
    check("s4_count", 32'(cnt1), 32'd16);

    // Scenario 5: start pulses during busy and during DONE are ignored
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat = 0;
    repeat (20) begin @(negedge clk); lat++; end
    cfg_a = 16'h0000; cfg_b = 16'h0000;
    start1 = 1'b1;
    @(negedge clk);
    lat++;
    start1 = 1'b0;
    while (done1 !== 1'b1 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    check("s5_latency", 32'(lat), 32'd128);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("s5_no_restart", 32'(busy1), 32'd0);
    repeat (3) @(negedge clk);
    check("s5_still_idle", 32'(busy1), 32'd0);
    check("s5_sa0", 32'(ds0_1), 32'hAAAA);
    check("s5_sa1", 32'(ds1_1), 32'h5555);
    check("s5_count", 32'(cnt1), 32'd16);

    // Scenario 6: zero operands -> only SA1 faults are observable
    cfg_a = 16'h0000; cfg_b = 16'h0000; cfg_sel = 2'b10;
    run_dut(1, lat);
    check("s6_latency", 32'(lat), 32'd128);
    check("s6_sa0", 32'(ds0_1), 32'h0000);
    check("s6_sa1", 32'(ds1_1), 32'hFFFF);
    check("s6_count", 32'(cnt1), 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
